// File: rtl/program_scheduler.sv
// Round-robin preemptive program scheduler: tracks live program slots, saves and
// restores each slot's PC, and drives OSUsage/progIndex for address translation.
//
// state   | meaning
// OS_MODE | OS context; waits for os_return with at least one live slot
// SELECT  | round-robin search for the next live slot after progIndex
// RESUME  | one-cycle resume_valid pulse with the slot's saved PC
// RUN     | user program running; counts retired instructions
// SAVE    | store pc_in for the outgoing slot, then reselect or return to OS
module program_scheduler #(
    parameter int NUM_PROGS = 10,
    parameter int QUANTUM   = 64,
    parameter int PC_W      = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sched_enable,
    input  logic                 os_return,
    input  logic                 load_valid,
    input  logic [3:0]           load_index,
    input  logic [PC_W-1:0]      load_pc,
    input  logic                 instr_retire,
    input  logic                 prog_halt,
    input  logic                 syscall,
    input  logic [PC_W-1:0]      pc_in,
    output logic                 OSUsage,
    output logic [3:0]           progIndex,
    output logic                 resume_valid,
    output logic [PC_W-1:0]      resume_pc,
    output logic [NUM_PROGS-1:0] live_mask
);

    localparam int CNT_W = $clog2(QUANTUM) + 1;

    typedef enum logic [2:0] {
        OS_MODE,
        SELECT,
        RESUME,
        RUN,
        SAVE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] quantum_cnt;
    logic [PC_W-1:0]  pc_table [NUM_PROGS];
    logic             pending;
    logic             sel_found;
    logic [3:0]       sel_idx;
    logic [PC_W-1:0]  cur_pc;
    logic             expiry;
    logic             run_exit;
    logic             halt_take;

    // Slots above progIndex take priority; the wrap segment (0..progIndex) is
    // searched second, so progIndex itself is the last candidate.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = progIndex;
        for (int j = NUM_PROGS - 1; j >= 0; j--) begin
            if (live_mask[j] && (4'(j) <= progIndex)) begin
                sel_found = 1'b1;
                sel_idx   = 4'(j);
            end
        end
        for (int j = NUM_PROGS - 1; j >= 0; j--) begin
            if (live_mask[j] && (4'(j) > progIndex)) begin
                sel_found = 1'b1;
                sel_idx   = 4'(j);
            end
        end
    end

    always_comb begin
        cur_pc = '0;
        for (int j = 0; j < NUM_PROGS; j++) begin
            if (progIndex == 4'(j)) begin
                cur_pc = pc_table[j];
            end
        end
    end

    assign expiry    = instr_retire && (quantum_cnt == CNT_W'(QUANTUM - 1));
    assign run_exit  = syscall || prog_halt || expiry || !sched_enable;
    assign halt_take = prog_halt && !syscall;

    always_comb begin
        state_next   = state;
        OSUsage      = 1'b1;
        resume_valid = 1'b0;
        resume_pc    = '0;
        case (state)
            OS_MODE: begin
                if (sched_enable && os_return && (live_mask != '0)) begin
                    state_next = SELECT;
                end
            end
            SELECT: begin
                state_next = sel_found ? RESUME : OS_MODE;
            end
            RESUME: begin
                OSUsage      = 1'b0;
                resume_valid = 1'b1;
                resume_pc    = cur_pc;
                state_next   = RUN;
            end
            RUN: begin
                OSUsage = 1'b0;
                if (run_exit) begin
                    state_next = SAVE;
                end
            end
            SAVE: begin
                state_next = pending ? OS_MODE : SELECT;
            end
            default: begin
                state_next = OS_MODE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= OS_MODE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            progIndex   <= '0;
            live_mask   <= '0;
            quantum_cnt <= '0;
            pending     <= 1'b0;
            for (int j = 0; j < NUM_PROGS; j++) begin
                pc_table[j] <= '0;
            end
        end else begin
            case (state)
                SELECT: begin
                    if (sel_found) begin
                        progIndex <= sel_idx;
                    end
                end
                RESUME: begin
                    quantum_cnt <= '0;
                end
                RUN: begin
                    if (instr_retire) begin
                        quantum_cnt <= quantum_cnt + CNT_W'(1);
                    end
                    if (run_exit) begin
                        pending <= syscall || !sched_enable;
                    end
                    if (halt_take) begin
                        for (int j = 0; j < NUM_PROGS; j++) begin
                            if (progIndex == 4'(j)) begin
                                live_mask[j] <= 1'b0;
                            end
                        end
                    end
                end
                SAVE: begin
                    for (int j = 0; j < NUM_PROGS; j++) begin
                        if (progIndex == 4'(j)) begin
                            pc_table[j] <= pc_in;
                        end
                    end
                    pending <= 1'b0;
                end
                default: begin
                end
            endcase
            // Placed last so a load overrides a same-cycle halt or save.
            if (load_valid) begin
                for (int j = 0; j < NUM_PROGS; j++) begin
                    if (load_index == 4'(j)) begin
                        live_mask[j] <= 1'b1;
                        pc_table[j]  <= load_pc;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_program_scheduler.sv
// Bench for program_scheduler: vector table with a scoreboard queue, plus a
// free-running sequence that times round-robin dispatch under constant retires.
module tb_program_scheduler;

    logic        clock;
    logic        reset;
    logic        sched_enable;
    logic        os_return;
    logic        load_valid;
    logic [3:0]  load_index;
    logic [11:0] load_pc;
    logic        instr_retire;
    logic        prog_halt;
    logic        syscall;
    logic [11:0] pc_in;
    logic        OSUsage;
    logic [3:0]  progIndex;
    logic        resume_valid;
    logic [11:0] resume_pc;
    logic [9:0]  live_mask;

    program_scheduler #(
        .NUM_PROGS(10),
        .QUANTUM  (4),
        .PC_W     (12)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sched_enable(sched_enable),
        .os_return   (os_return),
        .load_valid  (load_valid),
        .load_index  (load_index),
        .load_pc     (load_pc),
        .instr_retire(instr_retire),
        .prog_halt   (prog_halt),
        .syscall     (syscall),
        .pc_in       (pc_in),
        .OSUsage     (OSUsage),
        .progIndex   (progIndex),
        .resume_valid(resume_valid),
        .resume_pc   (resume_pc),
        .live_mask   (live_mask)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        rst;
        logic        se;
        logic        osr;
        logic        lv;
        logic [3:0]  li;
        logic [11:0] lpc;
        logic        ir;
        logic        ph;
        logic        sc;
        logic [11:0] pcin;
        logic        e_os;
        logic [3:0]  e_pi;
        logic        e_rv;
        logic [11:0] e_rpc;
        logic [9:0]  e_lm;
    } vec_t;

    typedef struct {
        int          id;
        logic        os;
        logic [3:0]  pi;
        logic        rv;
        logic [11:0] rpc;
        logic [9:0]  lm;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic se, input logic osr,
                                input logic lv, input logic [3:0] li, input logic [11:0] lpc,
                                input logic ir, input logic ph, input logic sc,
                                input logic [11:0] pcin, input logic eos, input logic [3:0] epi,
                                input logic erv, input logic [11:0] erpc, input logic [9:0] elm);
        vec_t v;
        v.rst = rst;  v.se = se;   v.osr = osr; v.lv = lv;   v.li = li;
        v.lpc = lpc;  v.ir = ir;   v.ph = ph;   v.sc = sc;   v.pcin = pcin;
        v.e_os = eos; v.e_pi = epi; v.e_rv = erv; v.e_rpc = erpc; v.e_lm = elm;
        return v;
    endfunction

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("v%0d.OSUsage", e.id), 32'(OSUsage), 32'(e.os));
            chk($sformatf("v%0d.progIndex", e.id), 32'(progIndex), 32'(e.pi));
            chk($sformatf("v%0d.resume_valid", e.id), 32'(resume_valid), 32'(e.rv));
            chk($sformatf("v%0d.live_mask", e.id), 32'(live_mask), 32'(e.lm));
            if (e.rv) begin
                chk($sformatf("v%0d.resume_pc", e.id), 32'(resume_pc), 32'(e.rpc));
            end
        end
    end

    task automatic wait_rv(input int limit, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < limit) begin
            @(posedge clock);
            @(negedge clock);
            n++;
            if (resume_valid) ok = 1'b1;
        end
    endtask

    initial begin
        int n;
        bit ok;
        exp_t e;

        reset = 1'b0; sched_enable = 1'b1; os_return = 1'b0; load_valid = 1'b0;
        load_index = '0; load_pc = '0; instr_retire = 1'b0; prog_halt = 1'b0;
        syscall = 1'b0; pc_in = '0;

        //            rst se osr lv li    lpc      ir ph sc pcin     os pi    rv rpc      lm
        vecs.push_back(mk(0, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 1, 4'd0, 0, 12'h000, 10'h000));
        vecs.push_back(mk(1, 1, 0, 1, 4'd2, 12'h010, 0, 0, 0, 12'h000, 1, 4'd0, 0, 12'h000, 10'h004));
        vecs.push_back(mk(1, 1, 0, 1, 4'd5, 12'h020, 0, 0, 0, 12'h000, 1, 4'd0, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 1, 4'd12,12'h0FF, 0, 0, 0, 12'h000, 1, 4'd0, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 1, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 1, 4'd0, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd2, 1, 12'h010, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd2, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 1, 0, 0, 12'h000, 0, 4'd2, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 1, 0, 0, 12'h000, 0, 4'd2, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 1, 0, 0, 12'h000, 0, 4'd2, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 1, 0, 0, 12'h014, 1, 4'd2, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h014, 1, 4'd2, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd5, 1, 12'h020, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd5, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 1, 0, 0, 12'h000, 0, 4'd5, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 1, 0, 0, 12'h000, 0, 4'd5, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 1, 0, 0, 12'h000, 0, 4'd5, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 1, 0, 0, 12'h000, 1, 4'd5, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h024, 1, 4'd5, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd2, 1, 12'h014, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd2, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 1, 0, 0, 12'h000, 0, 4'd2, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 1, 0, 0, 12'h000, 0, 4'd2, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 1, 0, 0, 12'h000, 0, 4'd2, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 1, 0, 1, 12'h033, 1, 4'd2, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h033, 1, 4'd2, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 1, 1, 1, 12'h000, 1, 4'd2, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 1, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 1, 4'd2, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd5, 1, 12'h024, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd5, 0, 12'h000, 10'h024));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 1, 0, 12'h02A, 1, 4'd5, 0, 12'h000, 10'h004));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h02A, 1, 4'd5, 0, 12'h000, 10'h004));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd2, 1, 12'h033, 10'h004));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd2, 0, 12'h000, 10'h004));
        vecs.push_back(mk(1, 1, 0, 1, 4'd2, 12'h040, 0, 1, 0, 12'h000, 1, 4'd2, 0, 12'h000, 10'h004));
        vecs.push_back(mk(1, 1, 0, 1, 4'd2, 12'h050, 0, 0, 0, 12'h099, 1, 4'd2, 0, 12'h000, 10'h004));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd2, 1, 12'h050, 10'h004));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd2, 0, 12'h000, 10'h004));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 1, 0, 12'h000, 1, 4'd2, 0, 12'h000, 10'h000));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 1, 4'd2, 0, 12'h000, 10'h000));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 1, 4'd2, 0, 12'h000, 10'h000));
        vecs.push_back(mk(1, 1, 1, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 1, 4'd2, 0, 12'h000, 10'h000));
        vecs.push_back(mk(1, 1, 0, 1, 4'd9, 12'h090, 0, 0, 0, 12'h000, 1, 4'd2, 0, 12'h000, 10'h200));
        vecs.push_back(mk(1, 0, 1, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 1, 4'd2, 0, 12'h000, 10'h200));
        vecs.push_back(mk(1, 1, 1, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 1, 4'd2, 0, 12'h000, 10'h200));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd9, 1, 12'h090, 10'h200));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd9, 0, 12'h000, 10'h200));
        vecs.push_back(mk(1, 0, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 1, 4'd9, 0, 12'h000, 10'h200));
        vecs.push_back(mk(1, 0, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h09C, 1, 4'd9, 0, 12'h000, 10'h200));
        vecs.push_back(mk(1, 1, 1, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 1, 4'd9, 0, 12'h000, 10'h200));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd9, 1, 12'h09C, 10'h200));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd9, 0, 12'h000, 10'h200));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 12'h000, 1, 0, 0, 12'h000, 0, 4'd9, 0, 12'h000, 10'h200));
        vecs.push_back(mk(0, 1, 0, 0, 4'd0, 12'h000, 1, 0, 0, 12'h000, 1, 4'd0, 0, 12'h000, 10'h000));
        vecs.push_back(mk(1, 1, 1, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 1, 4'd0, 0, 12'h000, 10'h000));

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset        = vecs[i].rst;
            sched_enable = vecs[i].se;
            os_return    = vecs[i].osr;
            load_valid   = vecs[i].lv;
            load_index   = vecs[i].li;
            load_pc      = vecs[i].lpc;
            instr_retire = vecs[i].ir;
            prog_halt    = vecs[i].ph;
            syscall      = vecs[i].sc;
            pc_in        = vecs[i].pcin;
            @(posedge clock);
            #1;
            e.id  = i;
            e.os  = vecs[i].e_os;
            e.pi  = vecs[i].e_pi;
            e.rv  = vecs[i].e_rv;
            e.rpc = vecs[i].e_rpc;
            e.lm  = vecs[i].e_lm;
            sb.push_back(e);
            @(negedge clock);
            #1;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        // Back-to-back quanta with instr_retire held high across every state.
        reset = 1'b1; os_return = 1'b0; sched_enable = 1'b1;
        load_valid = 1'b1; load_index = 4'd3; load_pc = 12'h030;
        @(posedge clock); #1;
        load_index = 4'd7; load_pc = 12'h070;
        @(posedge clock); #1;
        load_valid = 1'b0; os_return = 1'b1;
        @(posedge clock); #1;
        os_return = 1'b0; instr_retire = 1'b1; pc_in = 12'h0AB;

        wait_rv(10, n, ok);
        chk("rr1_dispatch_seen", 32'(ok), 32'd1);
        chk("rr1_progIndex", 32'(progIndex), 32'd3);
        chk("rr1_resume_pc", 32'(resume_pc), 32'h030);

        wait_rv(20, n, ok);
        chk("rr2_dispatch_seen", 32'(ok), 32'd1);
        chk("rr2_gap_cycles", 32'(n), 32'd7);
        chk("rr2_progIndex", 32'(progIndex), 32'd7);
        chk("rr2_resume_pc", 32'(resume_pc), 32'h070);

        wait_rv(20, n, ok);
        chk("rr3_dispatch_seen", 32'(ok), 32'd1);
        chk("rr3_gap_cycles", 32'(n), 32'd7);
        chk("rr3_progIndex", 32'(progIndex), 32'd3);
        chk("rr3_resume_pc", 32'(resume_pc), 32'h0AB);
        chk("rr3_OSUsage", 32'(OSUsage), 32'd0);

        instr_retire = 1'b0;
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
